// File: rtl/sat_cnt_multi.sv
// sat_cnt_multi: NCH independent up/down counters, each saturating at 0 and MAXV.
// Each channel reports its count, a "count <= THRESH" flag and saturation flags.
// Optional feature macro: SAT_CNT_OVF_EN enables the sticky per-channel
// overflow/underflow flag on ovf_o. Without it, ovf_o is tied to 0.
module sat_cnt_multi #(
    parameter int unsigned NCH    = 4,
    parameter int unsigned WIDTH  = 4,
    parameter int unsigned MAXV   = 15,
    parameter int unsigned THRESH = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [NCH-1:0]       clr,
    input  logic [NCH-1:0]       inc,
    input  logic [NCH-1:0]       dec,
    output logic [NCH*WIDTH-1:0] cnt_o,
    output logic [NCH-1:0]       le_thr,
    output logic [NCH-1:0]       sat_hi,
    output logic [NCH-1:0]       sat_lo,
    output logic [NCH-1:0]       ovf_o
);

    // One extra bit so compares against MAXV = 2^WIDTH-1 never lose a carry
    localparam int unsigned   CW     = WIDTH + 1;
    localparam logic [CW-1:0] MAXV_W = CW'(MAXV);
    localparam logic [CW-1:0] THR_W  = CW'(THRESH);

    // Reject illegal configurations at elaboration instead of truncating
    if (NCH < 1) begin : g_bad_nch
        $error("sat_cnt_multi: NCH must be >= 1");
    end
    if (WIDTH < 1) begin : g_bad_width
        $error("sat_cnt_multi: WIDTH must be >= 1");
    end
    if (MAXV < 1) begin : g_bad_maxv_lo
        $error("sat_cnt_multi: MAXV must be >= 1");
    end
    if ((MAXV >> WIDTH) != 0) begin : g_bad_maxv_hi
        $error("sat_cnt_multi: MAXV must fit in WIDTH bits");
    end
    if (THRESH > MAXV) begin : g_bad_thresh
        $error("sat_cnt_multi: THRESH must be <= MAXV");
    end

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        logic [WIDTH-1:0] cnt_q;
        logic [WIDTH-1:0] cnt_d;
        logic [CW-1:0]    cnt_ext;
        logic             up;
        logic             dn;

        assign cnt_ext = {1'b0, cnt_q};
        // inc and dec together cancel; en gates both but never clr
        assign up      = en & inc[g] & ~dec[g];
        assign dn      = en & dec[g] & ~inc[g];

        // Next count: clear first, then saturating step
        always_comb begin
            cnt_d = cnt_q;
            if (clr[g]) begin
                cnt_d = '0;
            end else if (up && (cnt_ext < MAXV_W)) begin
                cnt_d = cnt_q + WIDTH'(1);
            end else if (dn && (cnt_q != '0)) begin
                cnt_d = cnt_q - WIDTH'(1);
            end
        end

        // Count register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_d;
            end
        end

        assign cnt_o[g*WIDTH +: WIDTH] = cnt_q;
        assign le_thr[g]               = (cnt_ext <= THR_W);
        assign sat_hi[g]               = (cnt_ext == MAXV_W);
        assign sat_lo[g]               = (cnt_q == '0);

`ifdef SAT_CNT_OVF_EN
        logic ovf_q;
        logic ovf_d;

        // Sticky flag: set by a step pushing past a bound, cleared by clr
        always_comb begin
            ovf_d = ovf_q;
            if (clr[g]) begin
                ovf_d = 1'b0;
            end else if ((up && sat_hi[g]) || (dn && sat_lo[g])) begin
                ovf_d = 1'b1;
            end
        end

        // Overflow register
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                ovf_q <= 1'b0;
            end else begin
                ovf_q <= ovf_d;
            end
        end

        assign ovf_o[g] = ovf_q;
`else
        assign ovf_o[g] = 1'b0;
`endif
    end

endmodule

// File: doc/sat_cnt_multi.md
Name: sat_cnt_multi

Overview:
- Parametrised, multi-channel successor to the 2-bit saturating event counter. NCH independent up/down counters, each saturating at 0 and MAXV.
- Each channel exposes its count, a "count <= THRESH" flag, and saturation flags.
- Used wherever the design needs "allow N more events" gating, such as retry budgets, credit limits and miss counters, across several sources at once.

Parameters:
- NCH, 4, number of independent channels (>= 1).
- WIDTH, 4, bits per channel counter (>= 1).
- MAXV, 15, saturation ceiling; legal range 1 <= MAXV <= 2^WIDTH-1.
- THRESH, 2, compare threshold for le_thr; legal range 0 <= THRESH <= MAXV.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-high reset.
- en  input  1  global enable; when 0, inc/dec are ignored on all channels (clr still acts).
- clr  input  NCH  per-channel synchronous clear to 0.
- inc  input  NCH  per-channel increment request.
- dec  input  NCH  per-channel decrement request.
- cnt_o  output  NCH*WIDTH  channel counts; channel i occupies bits [i*WIDTH +: WIDTH].
- le_thr  output  NCH  1 when channel count <= THRESH.
- sat_hi  output  NCH  1 when channel count == MAXV.
- sat_lo  output  NCH  1 when channel count == 0.
- ovf_o  output  NCH  sticky overflow/underflow flag; only functional with the optional feature.

Behaviour:
- Reset: on rst high, asynchronously and without waiting for a clock edge:
  - all counts = 0, so cnt_o = 0;
  - le_thr = all 1s, sat_lo = all 1s, sat_hi = 0;
  - ovf_o = 0.
- Reset held: state stays at reset values while rst = 1. On release, the first update is at the next rising clk edge.
- Per channel i, the next state is decided per edge with this priority:
  1. clr[i] = 1 -> count = 0, regardless of en/inc/dec.
  2. en = 0 -> hold.
  3. inc = 1, dec = 0 -> count+1 if count < MAXV, else hold at MAXV.
  4. inc = 0, dec = 1 -> count-1 if count > 0, else hold at 0.
  5. inc = dec = 1 -> hold (net zero). This is not an overflow even at the bounds.
  6. otherwise -> hold.
- Wrap-around: never. Counts do not wrap at MAXV or 0, including MAXV = 2^WIDTH-1.
- Latency: one cycle from request to updated cnt_o.
- Flag timing: le_thr, sat_hi and sat_lo are combinational from registered state. They change in the same cycle as cnt_o, with no extra register stage.
- Channel independence: channels are fully independent; simultaneous activity on different channels is legal and non-interfering.
- Internal arithmetic: done at WIDTH+1 bits or by compare-before-add, so the MAXV = 2^WIDTH-1 bound is exact with no carry loss.
- Parameter checks: illegal parameter combinations are caught by an elaboration-time check ($error in a generate-if) and never silently truncated.
- Degenerate case: MAXV = 3, THRESH = 2, NCH = 1 with dec tied 0 reproduces the legacy 2-bit saturating counter and its "count <= 2" output.

Optional Feature:
- Macro: SAT_CNT_OVF_EN.
- Defined:
  - ovf_o[i] sets on a clock edge where en = 1, clr[i] = 0, and either inc[i] = 1, dec[i] = 0 with count == MAXV, or dec[i] = 1, inc[i] = 0 with count == 0.
  - Once set, it stays set (sticky) until clr[i] or rst.
  - clr[i] has priority over a same-cycle set: the result is 0.
- Not defined: the port still exists, ovf_o is tied to 0, and no flag registers are synthesised.

Test Plan:
1. Reset with defaults: assert rst mid-count with ch0 = 7 and no clock edge -> cnt_o = 0 immediately, le_thr = 4'hF, sat_lo = 4'hF, sat_hi = 0, ovf_o = 0.
2. Saturation with en = 1: 20 cycles of inc[0] -> ch0 = 1,2,...,15 then held at 15, sat_hi[0] = 1 from cycle 15. le_thr[0] drops when ch0 goes 2->3. With SAT_CNT_OVF_EN, ovf_o[0] = 1 from cycle 16.
3. Underflow: ch1 = 1, then 3 cycles of dec[1] -> 0, 0, 0; sat_lo[1] = 1. With the macro, ovf_o[1] sets on the second dec.
4. Simultaneous events: ch2 = 5 with inc[2] = dec[2] = 1 -> holds at 5. ch2 = 15 with inc = dec = 1 -> holds at 15, ovf unchanged. clr[2] together with inc[2] -> 0, and ovf_o[2] cleared.
5. Global gate: en = 0 with inc = 4'hF for 5 cycles -> all counts unchanged. en = 0 with clr[3] = 1 -> ch3 = 0.
6. Legacy configuration NCH = 1, WIDTH = 2, MAXV = 3, THRESH = 2: inc pulses -> count 0,1,2,3,3. le_thr = 1,1,1,0,0.
